// File: rtl/pipe_ctrl_pkg.sv
// Shared types and helpers for the pipeline stall/flush sequencer.
// State encoding, default mul/div latencies and a saturating adder.
package pipe_ctrl_pkg;

    typedef enum logic {
        RUN     = 1'b0,
        MD_WAIT = 1'b1
    } md_state_e;

    localparam int DEF_MUL_CYCLES = 4;
    localparam int DEF_DIV_CYCLES = 32;

    // Operands are widened to 64 bits so one helper serves any statistic width up to 64.
    function automatic logic [63:0] sat_add(input logic [63:0] a,
                                            input logic [63:0] b,
                                            input logic [63:0] max);
        logic [63:0] sum;
        sum = a + b;
        if (sum > max || sum < a)
            return max;
        return sum;
    endfunction

endpackage

// File: rtl/md_latency_counter.sv
// Mul/div latency down-counter: load, decrement, hold, zero flag.
module md_latency_counter #(
    parameter int CNT_WIDTH = 6
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 hold,
    input  logic                 load,
    input  logic                 dec,
    input  logic [CNT_WIDTH-1:0] load_val,
    output logic [CNT_WIDTH-1:0] cnt,
    output logic                 zero
);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            cnt <= '0;
        else if (hold)
            cnt <= cnt;
        else if (load)
            cnt <= load_val;
        else if (dec && cnt != '0)
            cnt <= cnt - 1'b1;
    end

    assign zero = (cnt == '0);

endmodule

// File: rtl/pipeline_control_unit.sv
// Central stall/flush sequencer for the 5-stage pipeline: prioritised hazard
// requests -> per-stage enables/flushes, mul/div wait FSM, stall statistic.
module pipeline_control_unit
    import pipe_ctrl_pkg::*;
#(
    parameter int MUL_CYCLES = DEF_MUL_CYCLES,
    parameter int DIV_CYCLES = DEF_DIV_CYCLES,
    parameter int CNT_WIDTH  = 6,
    parameter int STAT_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  ld_use_hazard,
    input  logic                  branch_taken,
    input  logic                  md_start,
    input  logic                  md_is_div,
    input  logic                  dmem_wait,
    output logic                  pc_write,
    output logic                  ifid_write,
    output logic                  ifid_flush,
    output logic                  idex_write,
    output logic                  idex_flush,
    output logic                  exmem_write,
    output logic                  exmem_flush,
    output logic                  memwb_flush,
    output logic                  md_busy,
    output logic                  md_done,
    output logic [STAT_WIDTH-1:0] stall_count
);

    md_state_e            state, state_nxt;
    logic                 cnt_load, cnt_dec, cnt_zero;
    logic [CNT_WIDTH-1:0] cnt, cnt_init;

    assign cnt_init = md_is_div ? CNT_WIDTH'(DIV_CYCLES - 1) : CNT_WIDTH'(MUL_CYCLES - 1);

    md_latency_counter #(.CNT_WIDTH(CNT_WIDTH)) u_cnt (
        .clk      (clk),
        .rst      (rst),
        .hold     (dmem_wait),
        .load     (cnt_load),
        .dec      (cnt_dec),
        .load_val (cnt_init),
        .cnt      (cnt),
        .zero     (cnt_zero)
    );

    always_comb begin
        pc_write    = 1'b1;
        ifid_write  = 1'b1;
        ifid_flush  = 1'b0;
        idex_write  = 1'b1;
        idex_flush  = 1'b0;
        exmem_write = 1'b1;
        exmem_flush = 1'b0;
        memwb_flush = 1'b0;
        md_done     = 1'b0;
        cnt_load    = 1'b0;
        cnt_dec     = 1'b0;
        state_nxt   = state;
        if (dmem_wait) begin
            pc_write    = 1'b0;
            ifid_write  = 1'b0;
            idex_write  = 1'b0;
            exmem_write = 1'b0;
            memwb_flush = 1'b1;
        end else if ((state == RUN && md_start) || (state == MD_WAIT && !cnt_zero)) begin
            pc_write    = 1'b0;
            ifid_write  = 1'b0;
            idex_write  = 1'b0;
            exmem_write = 1'b0;
            exmem_flush = 1'b1;
            if (state == RUN) begin
                cnt_load  = 1'b1;
                state_nxt = MD_WAIT;
            end else begin
                cnt_dec = 1'b1;
            end
        end else if (state == MD_WAIT) begin
            // Result ready: EX advances this cycle; branch/load-use re-presented next cycle.
            md_done   = 1'b1;
            state_nxt = RUN;
        end else if (branch_taken) begin
            ifid_flush = 1'b1;
            idex_flush = 1'b1;
        end else if (ld_use_hazard) begin
            pc_write   = 1'b0;
            ifid_write = 1'b0;
            idex_flush = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= RUN;
            md_busy <= 1'b0;
        end else begin
            state   <= state_nxt;
            md_busy <= (state_nxt == MD_WAIT);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            stall_count <= '0;
        else if (!pc_write)
            stall_count <= STAT_WIDTH'(sat_add(64'(stall_count), 64'd1, 64'({STAT_WIDTH{1'b1}})));
    end

endmodule

// File: doc/pipeline_control_unit.md
# pipeline_control_unit

Central stall/flush sequencer for the 5-stage MIPS pipeline. It collects hazard requests and produces one coherent set of per-stage write-enables and flushes each cycle. Requests come from the load-use hazard detector, EX-stage branch resolution, the multi-cycle multiply/divide unit and data-memory wait. It owns the mul/div latency counter and a saturating stall-cycle statistic.

## Interface

Parameters:
- MUL_CYCLES, 4, multiply latency in cycles (≥1)
- DIV_CYCLES, 32, divide latency in cycles (≥1)
- CNT_WIDTH, 6, latency counter width (must hold DIV_CYCLES-1)
- STAT_WIDTH, 32, stall statistic width

Ports:
- clk  in  1  single clock, rising edge
- rst  in  1  reset, asynchronous, active-low
- ld_use_hazard  in  1  load-use hazard from hazard detection unit (active when it drops PC_write)
- branch_taken  in  1  branch/jump resolved taken in EX
- md_start  in  1  mul/div instruction present in EX
- md_is_div  in  1  1 = divide, 0 = multiply; valid with md_start
- dmem_wait  in  1  data memory not ready for the MEM-stage access
- pc_write  out  1  PC update enable
- ifid_write  out  1  IF/ID register enable
- ifid_flush  out  1  zero IF/ID
- idex_write  out  1  ID/EX register enable
- idex_flush  out  1  insert bubble into ID/EX
- exmem_write  out  1  EX/MEM register enable
- exmem_flush  out  1  insert bubble into EX/MEM
- memwb_flush  out  1  insert bubble into MEM/WB
- md_busy  out  1  state is MD_WAIT
- md_done  out  1  one-cycle pulse; mul/div result valid, EX advances
- stall_count  out  STAT_WIDTH  cycles with pc_write=0, saturating

## Operation

- States: RUN, MD_WAIT. Down-counter cnt[CNT_WIDTH-1:0].
- Default (RUN, no requests): all *_write=1, all flushes=0.
- Priority, highest first; the first active rule sets the outputs:
  1. dmem_wait: all *_write=0, memwb_flush=1, other flushes 0. The FSM and cnt hold.
  2. MD in progress (RUN with md_start, or MD_WAIT with cnt≠0): pc/ifid/idex/exmem_write=0, exmem_flush=1.
  3. branch_taken (RUN only): pc_write=1, ifid_flush=1, idex_flush=1.
  4. ld_use_hazard: pc_write=0, ifid_write=0, idex_flush=1.
- Branch and load-use in the same cycle: branch wins. The dependent instruction is squashed anyway.
- branch_taken and ld_use_hazard are ignored in MD_WAIT. EX is frozen, so the sources re-present them after release.
- RUN with md_start and no dmem_wait: load cnt = (md_is_div ? DIV_CYCLES : MUL_CYCLES) − 1, then go to MD_WAIT.
- MD_WAIT with cnt≠0 and no dmem_wait: decrement cnt.
- MD_WAIT with cnt==0 and no dmem_wait: md_done=1, no MD stall (rules 3 and 4 do not apply), go to RUN.
- MD_WAIT with cnt==0 and dmem_wait: hold. md_done stays 0 until dmem_wait drops.
- stall_count increments on every cycle with pc_write=0 and saturates at all-ones.

## Timing

- All outputs except stall_count and md_busy are combinational from inputs and state. There is no extra latency.
- md_done is asserted exactly N cycles after the md_start cycle (N = MUL_CYCLES or DIV_CYCLES), absent dmem_wait. Each dmem_wait cycle adds one.
- The pipeline is stalled for N cycles per mul/div and advances on the md_done cycle.
- Reset (asynchronous, any time, including mid-MD_WAIT): state=RUN, cnt=0, stall_count=0, md_busy=0, md_done=0. With inputs low, the outputs take the default RUN values immediately.
- The first rising edge after rst deasserts is a normal RUN cycle.

## Structure

- Shared package/include pipe_ctrl_pkg: state encoding (RUN=0, MD_WAIT=1), default latency constants, a saturating-add helper.
- One sub-module, md_latency_counter: load/decrement/zero-flag counter with hold input. The FSM, priority mux and statistic stay at top level.

## Test plan

- Reset, then idle 5 cycles: all writes=1, flushes=0, stall_count=0. Assert rst low mid-divide (cnt=10): md_busy→0 asynchronously, next cycles default.
- md_start, md_is_div=0, held until md_done: pc_write=0 for 4 cycles, md_done on cycle 4, stall_count=4. Same with div: md_done on cycle 32, stall_count=32.
- ld_use_hazard for 1 cycle: pc_write=0, ifid_write=0, idex_flush=1 that cycle only, stall_count=1. With branch_taken in the same cycle: pc_write=1, ifid_flush=idex_flush=1, stall_count unchanged.
- MUL in flight; dmem_wait for 3 cycles at cnt==0: all writes 0, memwb_flush=1, md_done delayed to cycle 7.
- branch_taken during MD_WAIT: no ifid/idex flush; outputs match pure MD stall.
- Force stall_count to near max (STAT_WIDTH=4, 20 stall cycles): value stops at 15.
